fir_mac_param: RTL
==================

# fir_mac_param

Parametrised, coefficient-programmable FIR filter using one time-multiplexed multiply-accumulate unit. It is the next generation of the fixed 5-tap shift-and-add filter in the signal path and accepts samples through a valid/ready handshake. It computes y[n] = sum over k of c[k]·x[n−k] at full precision and emits one result per accepted sample. Coefficients reset to the legacy 5,4,3,2,1 profile and can be rewritten at run time through a register port.

## Interface
- `DATA_W`, default 32: sample width, signed two's complement.
- `COEF_W`, default 8: coefficient width, signed.
- `TAPS`, default 5: number of taps; must be ≥ 2.
- `ACC_W`, derived as DATA_W+COEF_W+$clog2(TAPS): accumulator and output width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear of the delay line and any in-flight computation.
- `x` in DATA_W: input sample.
- `in_valid` in 1: `x` is valid.
- `in_ready` out 1: block can accept a sample.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in $clog2(TAPS): tap index to write.
- `coef_data` in COEF_W: coefficient value to write.
- `coef_err` out 1: one-cycle pulse when a write is rejected.
- `dataout` out ACC_W: filter result; holds until the next result.
- `out_valid` out 1: one-cycle pulse when `dataout` updates.

## Operation
- **Reset** (`rst` low, asynchronous): all outputs and state clear.
  - State ← IDLE; delay line dl[0..TAPS-1] ← 0; accumulator ← 0.
  - `dataout`=0, `out_valid`=0, `coef_err`=0, `in_ready`=1 once `rst` is released.
  - c[k] ← TAPS−k, truncated to COEF_W. With TAPS=5 this gives 5,4,3,2,1.
  - A reset in the middle of a computation discards it; no `out_valid` is produced.
- **Handshake:** `in_ready` = (state==IDLE) && !`clr`. A sample is accepted when `in_valid`&&`in_ready` at a rising edge.
- **Accept edge:** dl shifts (dl[k] ← dl[k−1], dl[0] ← `x`); accumulator ← 0; tap index ← 0; state ← MAC.
- **MAC state:** each edge adds c[idx]·dl[idx] (signed, sign-extended to ACC_W) and increments idx.
  - On the edge where idx==TAPS−1, `dataout` ← acc + last product, `out_valid` pulses, and state ← IDLE.
- **Arithmetic:** full-precision signed arithmetic; no overflow is possible by construction of ACC_W. No rounding or saturation.
- **`clr`:**
  - In IDLE: zeroes dl.
  - In MAC: aborts the computation (no `out_valid`), zeroes dl and acc, and state ← IDLE.
  - `clr` together with `in_valid` drops the sample (`in_ready` is low).
- **Coefficient writes:**
  - Accepted only in IDLE with `coef_addr` < TAPS. They take effect on the next edge, so a sample accepted on the same edge already uses the new value.
  - A write during MAC, or with `coef_addr` ≥ TAPS, is ignored and `coef_err` pulses the following cycle.
- **Between results:** `dataout` holds its value when `out_valid` is low.

## Timing
- Sample accepted at edge T → product accumulation on edges T+1 … T+TAPS.
- `dataout`/`out_valid` are registered; `out_valid` is high in the cycle after edge T+TAPS.
- `in_ready` goes high in the same cycle as `out_valid`, so the earliest next accept is edge T+TAPS+1. Throughput is 1 sample per TAPS+1 cycles.
- `in_ready` is combinational from state and `clr` only; there is no path from `in_valid` to `in_ready`.
- `coef_err` is a registered pulse, 1 cycle after the offending write.

## Structure
- **Package `fir_pkg`:**
  - State enum {IDLE, MAC}.
  - Function `fir_acc_w(DATA_W,COEF_W,TAPS)`.
  - Function `fir_default_coef(k,TAPS)` returning TAPS−k.
- **Sub-module `fir_coef_bank`:** TAPS×COEF_W register file with asynchronous active-low reset to defaults, a write port with range check and busy gating, and a combinational read by index.
- **Top level:** delay line, FSM, index counter, MAC datapath, output register.

## Test plan
- **Impulse, default coefs, TAPS=5:** x=1 then 0,0,0,0,0 → `dataout` sequence 5,4,3,2,1,0, each `out_valid` 6 cycles apart.
- **Step:** constant x=1 → 5,9,12,14,15,15.
- **Signed:** x=−3 then zeros → −15,−12,−9,−6,−3. Also drive x=32'h7FFFFFFF with all coefs 127 → exact 64-bit-range sum, no wrap.
- **Reprogram in IDLE:** write c[0..4]=1 then step input → 1,2,3,4,5,5. A write to addr 5 → `coef_err` pulse and coefficients unchanged.
- **Busy behaviour:**
  - `in_valid` held high → `in_ready` low for exactly TAPS cycles per sample, no sample lost.
  - A coef write during MAC → `coef_err`, and the result uses the old coefs.
- **`clr` mid-MAC, then `rst` low mid-MAC:**
  - `clr` → no `out_valid`, next impulse response starts clean.
  - `rst` low → outputs 0 immediately, coefs back to 5,4,3,2,1.

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared types and helper functions for the time-multiplexed
//                coefficient-programmable FIR filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    // Controller states: waiting for a sample, or stepping through the taps
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MAC  = 1'b1
    } fir_state_t;

    // Accumulator width that can hold TAPS full-precision products without wrap
    function automatic int fir_acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Power-on coefficient profile: descending ramp TAPS, TAPS-1, ..., 1
    function automatic int fir_default_coef(input int k, input int taps);
        return taps - k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_coef_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fir_coef_bank
//  Description : TAPS x COEF_W coefficient register file. Resets to the
//                descending default profile, accepts range-checked writes
//                only while the datapath is idle, flags rejected writes with
//                a registered one-cycle error pulse, and offers a
//                combinational read port indexed by the tap counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int COEF_W = 8,
    parameter int TAPS   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       busy,
    input  logic                       we,
    input  logic [$clog2(TAPS)-1:0]    addr,
    input  logic [COEF_W-1:0]          wdata,
    output logic                       err,
    input  logic [$clog2(TAPS)-1:0]    rd_idx,
    output logic [COEF_W-1:0]          rd_coef
);

    localparam int AW = $clog2(TAPS);

    // TAPS expressed one bit wider than the address so the range check also
    // works when TAPS is a power of two
    localparam logic [AW:0] TAPS_L = (AW + 1)'(TAPS);

    logic [COEF_W-1:0] coef [TAPS];
    logic              addr_ok;
    logic              wr_ok;
    logic              wr_bad;

    assign addr_ok = ({1'b0, addr} < TAPS_L);
    assign wr_ok   = we && !busy && addr_ok;
    assign wr_bad  = we && (busy || !addr_ok);

    // Coefficient storage: defaults on reset, otherwise accepted writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= COEF_W'(fir_default_coef(k, TAPS));
            end
        end else if (wr_ok) begin
            coef[addr] <= wdata;
        end
    end

    // Rejected-write flag, one cycle after the offending strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= wr_bad;
        end
    end

    assign rd_coef = coef[rd_idx];

endmodule
`default_nettype wire

// File: rtl/fir_mac_param.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_param
//  Description : Parametrised FIR filter y[n] = sum c[k]*x[n-k] built around a
//                single multiply-accumulate unit that walks the taps one per
//                clock. Samples enter through a valid/ready handshake; one
//                full-precision result is produced per accepted sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_param
    import fir_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int COEF_W = 8,
    parameter int TAPS   = 5,
    parameter int ACC_W  = fir_acc_w(DATA_W, COEF_W, TAPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [DATA_W-1:0]          x,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic [COEF_W-1:0]          coef_data,
    output logic                       coef_err,
    output logic [ACC_W-1:0]           dataout,
    output logic                       out_valid
);

    localparam int              AW       = $clog2(TAPS);
    localparam int              PW       = DATA_W + COEF_W;
    localparam logic [AW-1:0]   LAST_IDX = AW'(TAPS - 1);

    fir_state_t              state;
    fir_state_t              state_nx;

    logic [DATA_W-1:0]       dl [TAPS];
    logic [AW-1:0]           idx;
    logic signed [ACC_W-1:0] acc;

    logic                    accept;
    logic                    busy;
    logic                    last_tap;
    logic [COEF_W-1:0]       cur_coef;
    logic [DATA_W-1:0]       cur_data;
    logic signed [PW-1:0]    coef_ext;
    logic signed [PW-1:0]    data_ext;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_sum;

    // Ready depends only on state and clr, never on in_valid
    assign in_ready = (state == IDLE) && !clr;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == MAC);
    assign last_tap = (idx == LAST_IDX);

    fir_coef_bank #(
        .COEF_W (COEF_W),
        .TAPS   (TAPS)
    ) u_coef_bank (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .we      (coef_we),
        .addr    (coef_addr),
        .wdata   (coef_data),
        .err     (coef_err),
        .rd_idx  (idx),
        .rd_coef (cur_coef)
    );

    // Multiply operands are sign-extended to the product width up front so the
    // signed multiply is exact without relying on context-width rules
    assign cur_data = dl[idx];
    assign coef_ext = {{DATA_W{cur_coef[COEF_W-1]}}, cur_coef};
    assign data_ext = {{COEF_W{cur_data[DATA_W-1]}}, cur_data};
    assign prod     = coef_ext * data_ext;
    assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
    assign acc_sum  = acc + prod_ext;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: start on accept, return to idle after the last tap or on clr
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = MAC;
                end
            end
            MAC: begin
                if (clr || last_tap) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Delay line, tap counter, accumulator and registered result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                dl[k] <= '0;
            end
            idx       <= '0;
            acc       <= '0;
            dataout   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == MAC) begin
                if (clr) begin
                    // Abort: drop the partial sum and history, no result
                    for (int k = 0; k < TAPS; k++) begin
                        dl[k] <= '0;
                    end
                    acc <= '0;
                    idx <= '0;
                end else begin
                    acc <= acc_sum;
                    idx <= idx + 1'b1;
                    if (last_tap) begin
                        dataout   <= acc_sum;
                        out_valid <= 1'b1;
                    end
                end
            end else begin
                if (clr) begin
                    for (int k = 0; k < TAPS; k++) begin
                        dl[k] <= '0;
                    end
                end else if (accept) begin
                    for (int k = TAPS - 1; k > 0; k--) begin
                        dl[k] <= dl[k-1];
                    end
                    dl[0] <= x;
                    acc   <= '0;
                    idx   <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire
